// File: rtl/pc_unit.sv
// pc_unit -- program counter with branch/jump redirect and stall handling.
//
// A taken branch or jump that arrives while memory is stalled is parked in a
// pending register (HOLD state) and applied on the first unstalled edge.
// Control inputs are ignored in HOLD.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   synchronous reset, active low
//   BUSYWAIT   in   memory stall, 1 holds the PC
//   JUMP       in   unconditional jump request
//   BRANCH     in   [1:0] 00 none, 01 beq, 10 bne, 11 reserved (none)
//   ZERO       in   ALU zero flag
//   OFFSET     in   [OFFSET_W-1:0] signed word offset
//   PC         out  [ADDR_W-1:0] registered program counter
//   PC_PLUS4   out  [ADDR_W-1:0] PC + 4, combinational, wraps
//   REDIRECT   out  one-cycle pulse: PC was loaded from a target last edge
//   TAKEN_CNT  out  [CNT_W-1:0] redirect count, saturating
//   STALL_CNT  out  [CNT_W-1:0] stalled-edge count, saturating
//
// Build option: define PC_PERF_CNT_EN to add TAKEN_CNT / STALL_CNT and
// their counters. Without it those ports do not exist.
module pc_unit #(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          OFFSET_W  = 8,
   parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                BUSYWAIT,
   input  logic                JUMP,
   input  logic [1:0]          BRANCH,
   input  logic                ZERO,
   input  logic [OFFSET_W-1:0] OFFSET,
   output logic [ADDR_W-1:0]   PC,
   output logic [ADDR_W-1:0]   PC_PLUS4,
   output logic                REDIRECT
`ifdef PC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    TAKEN_CNT,
   output logic [CNT_W-1:0]    STALL_CNT
`endif
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pend, pend_nxt;
   logic [ADDR_W-1:0]   pc_nxt;
   logic                redir_nxt;
   logic                taken;
   logic [ADDR_W-1:0]   off_ext;
   logic [ADDR_W-1:0]   target;

   assign PC_PLUS4 = PC + ADDR_W'(4);

   // JUMP dominates; BRANCH==11 falls through as "no branch".
   assign taken = JUMP
                | ((BRANCH == 2'b01) &  ZERO)
                | ((BRANCH == 2'b10) & ~ZERO);

   // Sign-extend the word offset, then scale to bytes; sum wraps naturally.
   assign off_ext = ADDR_W'($signed(OFFSET));
   assign target  = PC_PLUS4 + (off_ext << 2);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= RUN;
         PC       <= RESET_VEC;
         pend     <= '0;
         REDIRECT <= 1'b0;
      end else begin
         state    <= state_nxt;
         PC       <= pc_nxt;
         pend     <= pend_nxt;
         REDIRECT <= redir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
      pend_nxt  = pend;
      redir_nxt = 1'b0;
      case (state)
         RUN: begin
            if (!BUSYWAIT) begin
               pc_nxt    = taken ? target : PC_PLUS4;
               redir_nxt = taken;
            end else if (taken) begin
               // Decision made now, applied once the stall clears.
               pend_nxt  = target;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!BUSYWAIT) begin
               pc_nxt    = pend;
               redir_nxt = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

`ifdef PC_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         TAKEN_CNT <= '0;
         STALL_CNT <= '0;
      end else begin
         if (redir_nxt && (TAKEN_CNT != '1))
            TAKEN_CNT <= TAKEN_CNT + CNT_W'(1);
         if (BUSYWAIT && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of the program counter and all address outputs.
REQ-002 Parameter OFFSET_W, default 8: width of the signed branch/jump word offset.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 Parameter CNT_W, default 16: width of the performance counters (used only with PC_PERF_CNT_EN).
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RESET  in  1  synchronous, active-low reset.
REQ-007 BUSYWAIT  in  1  memory stall; 1 holds the PC.
REQ-008 JUMP  in  1  unconditional jump request.
REQ-009 BRANCH  in  2  branch mode: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
REQ-010 ZERO  in  1  ALU zero flag.
REQ-011 OFFSET  in  OFFSET_W  signed word offset, two's complement.
REQ-012 PC  out  ADDR_W  registered program counter.
REQ-013 PC_PLUS4  out  ADDR_W  combinational PC + 4, modulo 2^ADDR_W.
REQ-014 REDIRECT  out  1  registered one-cycle pulse; PC was loaded from a branch/jump target on the last edge.
REQ-015 TAKEN_CNT, STALL_CNT  out  CNT_W each  present only with PC_PERF_CNT_EN.

Function
REQ-016 taken = JUMP | (BRANCH==01 & ZERO) | (BRANCH==10 & ~ZERO); JUMP wins over any BRANCH value.
REQ-017 target = PC + 4 + (sign-extended OFFSET << 2), truncated to ADDR_W bits; no overflow flag.
REQ-018 The block has two states: RUN and HOLD.
REQ-019 RUN, BUSYWAIT=0: PC <= taken ? target : PC + 4; REDIRECT <= taken; stay in RUN.
REQ-020 RUN, BUSYWAIT=1, taken=1: latch target into an internal pending register; PC unchanged; REDIRECT <= 0; go to HOLD.
REQ-021 RUN, BUSYWAIT=1, taken=0: PC unchanged; REDIRECT <= 0; stay in RUN.
REQ-022 HOLD: JUMP, BRANCH, ZERO and OFFSET are ignored.
REQ-023 HOLD, BUSYWAIT=1: PC unchanged; REDIRECT <= 0; stay in HOLD.
REQ-024 HOLD, BUSYWAIT=0: PC <= pending target; REDIRECT <= 1; go to RUN.
REQ-025 Latency: one edge from an unstalled decision to the PC update; PC_PLUS4 follows PC combinationally.
REQ-026 PC + 4 and target wrap modulo 2^ADDR_W (for example, PC = FFFFFFFC with no branch yields 00000000).
REQ-027 A negative OFFSET at its most negative value (-2^(OFFSET_W-1)) gives target = PC + 4 - 2^(OFFSET_W+1), wrapped.

Reset
REQ-028 RESET=0 on a rising edge overrides BUSYWAIT, state and all other inputs.
REQ-029 On reset: PC <= RESET_VEC, state <= RUN, pending register <= 0, REDIRECT <= 0, counters <= 0.
REQ-030 Reset asserted while in HOLD discards the pending target; no redirect occurs after reset release.
REQ-031 On the first edge with RESET=1, normal RUN behaviour applies.

Configuration
REQ-032 The macro PC_PERF_CNT_EN controls the performance counters.
REQ-033 With PC_PERF_CNT_EN defined, TAKEN_CNT increments on every edge where REDIRECT is set to 1, and STALL_CNT increments on every edge where BUSYWAIT=1 and RESET=1.
REQ-034 Both counters saturate at all-ones and never wrap.
REQ-035 Without PC_PERF_CNT_EN, the counter ports and their logic do not exist; all other behaviour is identical.

Verification
REQ-036 Reset then 3 edges with no control inputs (RESET_VEC=0) -> PC = 0, 4, 8, 12; REDIRECT stays 0.
REQ-037 PC=0x10, BRANCH=01, ZERO=1, OFFSET=0xFE, BUSYWAIT=0 -> PC=0x0C next edge, REDIRECT=1 for one cycle; the same stimulus with ZERO=0 -> PC=0x14.
REQ-038 PC=0x20, JUMP=1, OFFSET=3, BUSYWAIT=1 for 3 edges with inputs changed to junk -> PC holds 0x20; on BUSYWAIT=0 -> PC=0x30, REDIRECT=1.
REQ-039 PC=0x40, enter HOLD, then RESET=0 for one edge -> PC=RESET_VEC, state RUN, REDIRECT=0, no later redirect to the pending target.
REQ-040 PC=0xFFFFFFFC, no branch -> PC=0x00000000; with PC_PERF_CNT_EN and CNT_W=4, 20 stall cycles -> STALL_CNT=0xF and held.
